// File: rtl/funct_generator_pkg.sv
// Shared types and default sizes for the waveform LUT sequencer.
// The optional burst mode (macro FGEN_BURST_EN) is configured in funct_generator_ctrl.
package funct_generator_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH  = 8;
  localparam int DEFAULT_PHASE_WIDTH = 16;
  localparam int DEFAULT_NUM_WAVES   = 4;

  // Sample buffer depth and the width of its occupancy count (0..SKID_DEPTH).
  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/funct_generator_skid.sv
// Two-entry in-order sample buffer with a valid/ready output and exported occupancy.
// The producer never pushes into a full buffer unless the same cycle pops.
module funct_generator_skid
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic [OCC_WIDTH-1:0]  occ
);

  // Handshake: a sample transfers on a cycle where valid & ready are both high;
  // while valid is high and ready is low, data and valid do not change.
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [OCC_WIDTH-1:0]  occ_q;
  logic                  pop;

  assign pop   = valid & ready;
  assign valid = (occ_q != 2'd0);
  assign data  = head_q;
  assign occ   = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_q <= push_data;
            occ_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= push_data;
          end else if (push) begin
            tail_q <= push_data;
            occ_q  <= 2'd2;
          end else if (pop) begin
            occ_q <= 2'd0;
          end
        end
        default: begin
          // Full: a push is only legal alongside a pop, so the tail shifts forward.
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= push_data;
            end else begin
              occ_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/funct_generator_ctrl.sv
// Phase-accumulator sequencer for a registered-read waveform LUT feeding a sample stream.
// Define FGEN_BURST_EN to add burst_len_i/done_o (auto-stop after a fixed number of issues).
module funct_generator_ctrl
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int NUM_WAVES   = DEFAULT_NUM_WAVES,
  localparam int SEL_WIDTH  = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [PHASE_WIDTH-1:0] freq_word_i,
  input  logic [SEL_WIDTH-1:0]   wave_sel_i,
  output logic [ADDR_WIDTH-1:0]  lut_addr_o,
  output logic [SEL_WIDTH-1:0]   lut_sel_o,
  input  logic [DATA_WIDTH-1:0]  lut_data_i,
  output logic [DATA_WIDTH-1:0]  sample_o,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic                   busy_o,
`ifdef FGEN_BURST_EN
  input  logic [15:0]            burst_len_i,
  output logic                   done_o,
`endif
  output logic                   wrap_o
);

  state_t                 state_q;
  state_t                 state_d;
  logic                   load;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [PHASE_WIDTH-1:0] fw_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   inflight_q;
  logic                   wrap_q;
  logic [OCC_WIDTH-1:0]   occ;
  logic                   pop;
  logic                   issue;
  logic                   burst_last;
  logic [2:0]             credit;
  logic [PHASE_WIDTH:0]   phase_sum;

  // A read is only issued if the buffer can still hold its data after this
  // cycle's pop, so the returning sample always has a free slot.
  assign pop       = sample_valid_o & sample_ready_i;
  assign credit    = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (credit < 3'(SKID_DEPTH));
  assign phase_sum = {1'b0, phase_q} + {1'b0, fw_q};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (stop_i || burst_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (occ == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      fw_q       <= '0;
      sel_q      <= '0;
      inflight_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      wrap_q     <= issue & phase_sum[PHASE_WIDTH];
      if (load) begin
        phase_q <= '0;
        fw_q    <= freq_word_i;
        sel_q   <= wave_sel_i;
      end else if (issue) begin
        phase_q <= phase_sum[PHASE_WIDTH-1:0];
      end
    end
  end

`ifdef FGEN_BURST_EN
  logic [15:0] burst_q;
  logic [15:0] issued_q;
  logic        done_q;

  // A zero burst length never matches, leaving the run continuous.
  assign burst_last = issue && (burst_q != 16'd0) && (issued_q == burst_q - 16'd1);
  assign done_o     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q  <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == DRAIN) && (state_d == IDLE);
      if (load) begin
        burst_q  <= burst_len_i;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 16'd1;
      end
    end
  end
`else
  assign burst_last = 1'b0;
`endif

  assign lut_addr_o = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign lut_sel_o  = sel_q;
  assign busy_o     = (state_q != IDLE);
  assign wrap_o     = wrap_q;

  // LUT data lags the address by one cycle, so the issue flag is delayed to match.
  funct_generator_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (lut_data_i),
    .data      (sample_o),
    .valid     (sample_valid_o),
    .ready     (sample_ready_i),
    .occ       (occ)
  );

endmodule

// File: tb/tb_funct_generator_ctrl.sv
// Self-checking bench for funct_generator_ctrl: registered LUT model, sample
// scoreboard built from the phase-accumulator rule, directed and random runs.
module tb_funct_generator_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int PW = 16;
  localparam int NW = 4;
  localparam int SW = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          sample_ready_i = 1'b0;
  logic [PW-1:0] freq_word_i = '0;
  logic [SW-1:0] wave_sel_i = '0;
  logic [AW-1:0] lut_addr_o;
  logic [SW-1:0] lut_sel_o;
  logic [DW-1:0] lut_data_i = '0;
  logic [DW-1:0] sample_o;
  logic          sample_valid_o;
  logic          busy_o;
  logic          wrap_o;
`ifdef FGEN_BURST_EN
  logic [15:0]   burst_len_i = 16'd0;
  logic          done_o;
`endif

  funct_generator_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .freq_word_i    (freq_word_i),
    .wave_sel_i     (wave_sel_i),
    .lut_addr_o     (lut_addr_o),
    .lut_sel_o      (lut_sel_o),
    .lut_data_i     (lut_data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .busy_o         (busy_o),
`ifdef FGEN_BURST_EN
    .burst_len_i    (burst_len_i),
    .done_o         (done_o),
`endif
    .wrap_o         (wrap_o)
  );

  // registered-read LUT model
  logic [DW-1:0] lut_mem [NW][2**AW];
  always @(posedge clk) lut_data_i <= lut_mem[lut_sel_o][lut_addr_o];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_done   = 0;
  logic [DW-1:0] exp_q[$];
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference: the k-th issue reads address (k*fw mod 2^PW) >> (PW-AW)
  function automatic logic [AW-1:0] model_addr(input int k, input logic [PW-1:0] fw);
    int p;
    p = (k * int'(fw)) % (1 << PW);
    return AW'(p >> (PW - AW));
  endfunction

  function automatic logic model_carry(input int k, input logic [PW-1:0] fw);
    int p;
    p = (k * int'(fw)) % (1 << PW);
    return (p + int'(fw)) >= (1 << PW);
  endfunction

  // scoreboard and stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v) begin
        check_eq("hold_valid", 64'(sample_valid_o), 64'(1));
        check_eq("hold_data", 64'(sample_o), 64'(hold_d));
      end
      if (sample_valid_o && sample_ready_i) begin
        if (exp_q.size() == 0) check_eq("extra_sample", 64'(sample_valid_o), 64'(0));
        else check_eq("sample", 64'(sample_o), 64'(exp_q.pop_front()));
        n_pop++;
      end
      hold_v = sample_valid_o && !sample_ready_i;
      hold_d = sample_o;
`ifdef FGEN_BURST_EN
      if (done_o) n_done++;
`endif
    end else begin
      hold_v = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_expect(input logic [PW-1:0] fw, input logic [SW-1:0] sel);
    exp_q.delete();
    n_pop = 0;
    for (int j = 0; j < 1024; j++) exp_q.push_back(lut_mem[sel][model_addr(j, fw)]);
  endtask

  task automatic start_run(input logic [PW-1:0] fw, input logic [SW-1:0] sel, input logic [15:0] blen);
    load_expect(fw, sel);
    freq_word_i = fw;
    wave_sel_i  = sel;
`ifdef FGEN_BURST_EN
    burst_len_i = blen;
`else
    if (blen != 16'd0) $display("note: burst length ignored in this build");
`endif
    start_i = 1'b1;
    tick();
    start_i     = 1'b0;
    freq_word_i = PW'($urandom);
    wave_sel_i  = SW'($urandom_range(0, NW - 1));
  endtask

  task automatic wait_idle(input int budget, input logic rand_ready);
    int cnt;
    cnt = 0;
    while (busy_o && cnt < budget) begin
      if (rand_ready) sample_ready_i = ($urandom_range(0, 3) != 0);
      tick();
      cnt++;
    end
    check_eq("drain_done", 64'(busy_o), 64'(0));
    sample_ready_i = 1'b1;
    tick();
    check_eq("idle_valid", 64'(sample_valid_o), 64'(0));
  endtask

  task automatic run_cont(input logic [PW-1:0] fw, input logic [SW-1:0] sel, input int ncyc);
    sample_ready_i = 1'b1;
    start_run(fw, sel, 16'd0);
    for (int k = 0; k < ncyc; k++) begin
      check_eq("addr", 64'(lut_addr_o), 64'(model_addr(k, fw)));
      check_eq("wrap", 64'(wrap_o), (k == 0) ? 64'(0) : 64'(model_carry(k - 1, fw)));
      if (k < 4) check_eq("latency_valid", 64'(sample_valid_o), 64'(k >= 2));
      if (k == 0) check_eq("lut_sel", 64'(lut_sel_o), 64'(sel));
      if (k == ncyc - 1) stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
    end
    wait_idle(50, 1'b0);
    check_eq("cont_count", 64'(n_pop), 64'(ncyc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < NW; w++)
      for (int a = 0; a < 2**AW; a++) lut_mem[w][a] = $urandom;

    // reset state
    tick();
    tick();
    check_eq("rst_addr", 64'(lut_addr_o), 64'(0));
    check_eq("rst_sel", 64'(lut_sel_o), 64'(0));
    check_eq("rst_sample", 64'(sample_o), 64'(0));
    check_eq("rst_valid", 64'(sample_valid_o), 64'(0));
    check_eq("rst_busy", 64'(busy_o), 64'(0));
    check_eq("rst_wrap", 64'(wrap_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // full table sweep, half-step, and descending sweep
    run_cont(16'h0100, 2'd0, 258);
    run_cont(16'h0080, 2'd1, 20);
    run_cont(16'hFF00, 2'd2, 20);
    run_cont(16'h0000, 2'd3, 8);

    // backpressure window mid-run
    sample_ready_i = 1'b1;
    start_run(16'h0100, 2'd3, 16'd0);
    repeat (5) tick();
    sample_ready_i = 1'b0;
    repeat (10) tick();
    check_eq("bp_valid", 64'(sample_valid_o), 64'(1));
    sample_ready_i = 1'b1;
    repeat (9) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_idle(50, 1'b0);
    check_eq("bp_count", 64'(n_pop), 64'(15));

    // stop with a full buffer; start during drain is ignored
    sample_ready_i = 1'b0;
    start_run(PW'($urandom), 2'd1, 16'd0);
    repeat (5) tick();
    stop_i = 1'b1;
    tick();
    stop_i  = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("drain_busy", 64'(busy_o), 64'(1));
    sample_ready_i = 1'b1;
    wait_idle(50, 1'b0);
    check_eq("drain_count", 64'(n_pop), 64'(2));

    // start+stop together: IDLE honours start, RUN honours stop
    sample_ready_i = 1'b1;
    load_expect(16'h0100, 2'd2);
    freq_word_i = 16'h0100;
    wave_sel_i  = 2'd2;
    start_i     = 1'b1;
    stop_i      = 1'b1;
    tick();
    check_eq("both_idle_run", 64'(busy_o), 64'(1));
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    wait_idle(50, 1'b0);
    check_eq("both_run_count", 64'(n_pop), 64'(1));

    // randomized runs with random backpressure
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(20, 80);
      sample_ready_i = 1'b1;
      start_run(PW'($urandom), SW'($urandom_range(0, NW - 1)), 16'd0);
      for (int c = 0; c < len; c++) begin
        sample_ready_i = ($urandom_range(0, 3) != 0);
        if (c == len - 1) stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
      end
      wait_idle(100, 1'b1);
    end

`ifdef FGEN_BURST_EN
    // burst of five samples then a single done pulse
    sample_ready_i = 1'b1;
    n_done = 0;
    start_run(16'h0100, 2'd0, 16'd5);
    wait_idle(50, 1'b0);
    tick();
    check_eq("burst_count", 64'(n_pop), 64'(5));
    check_eq("burst_done", 64'(n_done), 64'(1));
    burst_len_i = 16'd0;
`endif

    // asynchronous reset mid-run
    sample_ready_i = 1'b1;
    start_run(16'h0100, 2'd1, 16'd0);
    repeat (20) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_addr", 64'(lut_addr_o), 64'(0));
    check_eq("arst_sel", 64'(lut_sel_o), 64'(0));
    check_eq("arst_sample", 64'(sample_o), 64'(0));
    check_eq("arst_valid", 64'(sample_valid_o), 64'(0));
    check_eq("arst_busy", 64'(busy_o), 64'(0));
    check_eq("arst_wrap", 64'(wrap_o), 64'(0));
`ifdef FGEN_BURST_EN
    check_eq("arst_done", 64'(done_o), 64'(0));
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 64'(busy_o), 64'(0));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
